// File: rtl/fft_div_pkg.sv
// Shared types and constants for the FFT datapath sequential divider.
package fft_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int DEF_DIVIDEND_W = 32;
    localparam int DEF_DIVISOR_W  = 24;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int DIVISOR_W = 24
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] dvs_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_o
);

    localparam int RW = DIVISOR_W + 1;

    logic [DIVISOR_W+1:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {2'b00, dvs_i});
        rem_o   = q_o ? RW'(shifted - {2'b00, dvs_i}) : RW'(shifted);
    end

endmodule

// File: rtl/div32_24_seq.sv
// Sequential signed restoring divider (truncating, C semantics), one quotient bit per clock.
module div32_24_seq
    import fft_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic                  q_sign_q, q_sign_d;
    logic                  r_sign_q, r_sign_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;

    div_restore_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DIVIDEND_W-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        q_sign_d    = q_sign_q;
        r_sign_d    = r_sign_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_sign_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    r_sign_d = dividend[DIVIDEND_W-1];
                    dvd_d    = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                    dvs_d    = divisor[DIVISOR_W-1] ? -divisor : divisor;
                    rem_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    // A zero divisor still passes through FIX so its result
                    // appears one cycle after acceptance.
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    quotient_d  = r_sign_q ? Q_MIN : Q_MAX;
                    remainder_d = '0;
                end else begin
                    if (!q_sign_q && dvd_q == Q_MIN) begin
                        quotient_d = Q_MAX;
                        ovf_d      = 1'b1;
                    end else begin
                        quotient_d = q_sign_q ? -dvd_q : dvd_q;
                    end
                    remainder_d = r_sign_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            q_sign_q    <= q_sign_d;
            r_sign_q    <= r_sign_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div32_24_seq.sv
// Directed-vector and randomized bench for div32_24_seq.
module tb_div32_24_seq;
    import fft_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [23:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [23:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    div32_24_seq #(
        .DIVIDEND_W (32),
        .DIVISOR_W  (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [23:0] b;
        logic [31:0] q;
        logic [23:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one operation; optionally keep in_valid asserted with junk during
    // the calculation and stall out_ready for a number of cycles in DONE.
    task automatic run_op(input logic [31:0] a, input logic [23:0] b, input int stall,
                          input bit junk, output logic [31:0] q, output logic [23:0] r,
                          output logic dbz, output logic ovf, output int lat,
                          output bit stable);
        int n;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            dividend = $urandom;
            divisor  = 24'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        q = quotient;
        r = remainder;
        dbz = div_by_zero;
        ovf = overflow;
        stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || quotient !== q || remainder !== r ||
                div_by_zero !== dbz || overflow !== ovf) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic [23:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        bit          stable;
        logic [31:0] ra;
        logic [23:0] rb;
        logic [31:0] eq;
        logic [23:0] er;
        logic        edbz;
        logic        eovf;
        longint      sa;
        longint      sb;
        longint      lq;
        longint      lr;

        vecs[0]  = '{32'd100,       24'd7,         32'd14,        24'd2,        1'b0, 1'b0, 33};
        vecs[1]  = '{32'hFFFF_FF9C, 24'd7,         32'hFFFF_FFF2, 24'hFF_FFFE,  1'b0, 1'b0, 33};
        vecs[2]  = '{32'd100,       24'hFF_FFF9,   32'hFFFF_FFF2, 24'd2,        1'b0, 1'b0, 33};
        vecs[3]  = '{32'h8000_0000, 24'hFF_FFFF,   32'h7FFF_FFFF, 24'd0,        1'b0, 1'b1, 33};
        vecs[4]  = '{32'h8000_0000, 24'd2,         32'hC000_0000, 24'd0,        1'b0, 1'b0, 33};
        vecs[5]  = '{32'd1234,      24'd0,         32'h7FFF_FFFF, 24'd0,        1'b1, 1'b0, 1};
        vecs[6]  = '{32'hFFFF_FFFB, 24'd0,         32'h8000_0000, 24'd0,        1'b1, 1'b0, 1};
        vecs[7]  = '{32'h7FFF_FFFF, 24'h7F_FFFF,   32'h0000_0100, 24'h00_00FF,  1'b0, 1'b0, 33};
        vecs[8]  = '{32'hFFFF_FFF9, 24'hFF_FFFE,   32'd3,         24'hFF_FFFF,  1'b0, 1'b0, 33};
        vecs[9]  = '{32'd0,         24'd5,         32'd0,         24'd0,        1'b0, 1'b0, 33};
        vecs[10] = '{32'h8000_0000, 24'h80_0000,   32'h0000_0100, 24'd0,        1'b0, 1'b0, 33};
        vecs[11] = '{32'd9,         24'd3,         32'd3,         24'd0,        1'b0, 1'b0, 33};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, 1'b0, q, r, dbz, ovf, lat, stable);
            chk($sformatf("v%0d_quotient", i), 64'(q), 64'(vecs[i].q));
            chk($sformatf("v%0d_remainder", i), 64'(r), 64'(vecs[i].r));
            chk($sformatf("v%0d_div_by_zero", i), 64'(dbz), 64'(vecs[i].dbz));
            chk($sformatf("v%0d_overflow", i), 64'(ovf), 64'(vecs[i].ovf));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check_idle($sformatf("v%0d_after", i));
        end

        // Reset asserted after CALC step 10 of an operation.
        in_valid = 1'b1;
        dividend = 32'd100;
        divisor  = 24'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_idle("midreset");
        chk("midreset_quotient", 64'(quotient), 64'd0);
        chk("midreset_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(32'd9, 24'd3, 0, 1'b0, q, r, dbz, ovf, lat, stable);
        chk("postreset_quotient", 64'(q), 64'd3);
        chk("postreset_remainder", 64'(r), 64'd0);
        chk("postreset_latency", 64'(lat), 64'd33);

        // Stalled result with in_valid held high during the calculation.
        run_op(32'hFFFF_FF9C, 24'd7, 5, 1'b1, q, r, dbz, ovf, lat, stable);
        chk("stall_stable", 64'(stable), 64'd1);
        chk("stall_quotient", 64'(q), 64'hFFFF_FFF2);
        chk("stall_remainder", 64'(r), 64'hFF_FFFE);
        check_idle("stall_after");

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 15))
                0:       rb = 24'd0;
                1:       rb = 24'hFF_FFFF;
                2, 3, 4: rb = 24'($urandom_range(1, 300));
                5, 6:    rb = -24'($urandom_range(1, 300));
                default: rb = 24'($urandom);
            endcase
            if (rb == 24'd0) begin
                eq = ra[31] ? QMIN : QMAX;
                er = '0;
                edbz = 1'b1;
                eovf = 1'b0;
            end else if (ra == 32'h8000_0000 && rb == 24'hFF_FFFF) begin
                eq = QMAX;
                er = '0;
                edbz = 1'b0;
                eovf = 1'b1;
            end else begin
                sa = longint'($signed(ra));
                sb = longint'($signed(rb));
                lq = sa / sb;
                lr = sa % sb;
                eq = lq[31:0];
                er = lr[23:0];
                edbz = 1'b0;
                eovf = 1'b0;
            end
            run_op(ra, rb, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                   q, r, dbz, ovf, lat, stable);
            chk($sformatf("rnd%0d_quotient a=%h b=%h", i, ra, rb), 64'(q), 64'(eq));
            chk($sformatf("rnd%0d_remainder a=%h b=%h", i, ra, rb), 64'(r), 64'(er));
            chk($sformatf("rnd%0d_flags", i), 64'({dbz, ovf}), 64'({edbz, eovf}));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), edbz ? 64'd1 : 64'd33);
            chk($sformatf("rnd%0d_stable", i), 64'(stable), 64'd1);
            chk($sformatf("rnd%0d_in_ready", i), 64'(in_ready), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
